// File: rtl/gpio_cond_pkg.sv
// Shared constants and helpers for the GPIO input conditioner.
// The optional glitch statistics counter is enabled by GPIO_COND_GLITCH_STATS_EN.
package gpio_cond_pkg;

  localparam int unsigned DEF_SYNC_STAGES  = 2;
  localparam int unsigned DEF_PRESCALE_DIV = 1000;
  localparam int unsigned DEF_DB_COUNT     = 4;
  localparam int unsigned GLITCH_CNT_W     = 16;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One GPIO pin: synchroniser chain, prescaled stability counter, clean level and edge pulses.
module gpio_debounce_bit
  import gpio_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned DB_COUNT    = DEF_DB_COUNT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic bypass,
  input  logic sample_tick,
  output logic level,
  output logic rise,
  output logic fall,
  output logic glitch
);

  localparam int unsigned CntW = clog2(DB_COUNT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DB_COUNT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   syncd;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, fall_q;

  assign syncd = sync_q[SYNC_STAGES-1];

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    glitch  = 1'b0;
    if (bypass) begin
      level_d = syncd;
      cnt_d   = '0;
    end else if (syncd == level_q) begin
      // Input fell back to the accepted level before the count completed.
      cnt_d  = '0;
      glitch = (cnt_q != '0);
    end else if (sample_tick) begin
      if (cnt_q == CntLast) begin
        level_d = syncd;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= level_d & ~level_q;
      fall_q  <= ~level_d & level_q;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/gpio_input_conditioner.sv
// Synchronises and debounces raw GPIO pads for gpio_in, with per-pin rise/fall pulses.
// Define GPIO_COND_GLITCH_STATS_EN to add the saturating glitch_count output.
module gpio_input_conditioner
  import gpio_cond_pkg::*;
#(
  parameter int unsigned GPIO_WIDTH   = 32,
  parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int unsigned PRESCALE_DIV = DEF_PRESCALE_DIV,
  parameter int unsigned DB_COUNT     = DEF_DB_COUNT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [GPIO_WIDTH-1:0]   pins_raw,
  input  logic [GPIO_WIDTH-1:0]   bypass,
  output logic [GPIO_WIDTH-1:0]   pins_clean,
  output logic [GPIO_WIDTH-1:0]   rise_pulse,
  output logic [GPIO_WIDTH-1:0]   fall_pulse,
  output logic                    sample_tick
`ifdef GPIO_COND_GLITCH_STATS_EN
  ,
  output logic [GLITCH_CNT_W-1:0] glitch_count
`endif
);

  localparam int unsigned PreW = (PRESCALE_DIV > 1) ? clog2(PRESCALE_DIV) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(PRESCALE_DIV - 1);

  logic [PreW-1:0] pre_q, pre_d;
  logic            tick_q, tick_d;

  // Tick is registered alongside the count so it is high while the count sits at its last value.
  always_comb begin
    pre_d  = (pre_q == PreLast) ? '0 : pre_q + PreW'(1);
    tick_d = (pre_d == PreLast);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
    end
  end

  assign sample_tick = tick_q;

  logic [GPIO_WIDTH-1:0] glitch;

  for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_pin
    gpio_debounce_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_COUNT    (DB_COUNT)
    ) u_bit (
      .clk         (clk),
      .rst         (rst),
      .raw         (pins_raw[i]),
      .bypass      (bypass[i]),
      .sample_tick (tick_q),
      .level       (pins_clean[i]),
      .rise        (rise_pulse[i]),
      .fall        (fall_pulse[i]),
      .glitch      (glitch[i])
    );
  end

`ifdef GPIO_COND_GLITCH_STATS_EN
  logic [GLITCH_CNT_W-1:0] glitch_cnt_q;

  // Any number of pins rejecting in one cycle counts once; saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_cnt_q <= '0;
    end else if ((|glitch) && (glitch_cnt_q != '1)) begin
      glitch_cnt_q <= glitch_cnt_q + GLITCH_CNT_W'(1);
    end
  end

  assign glitch_count = glitch_cnt_q;
`else
  logic unused_glitch;
  assign unused_glitch = ^glitch;
`endif

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed self-checking bench for gpio_input_conditioner (8 pins, 2 sync stages, div 4, count 3).
module tb_gpio_input_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pins_raw = '0;
  logic [7:0] bypass = '0;
  logic [7:0] pins_clean, rise_pulse, fall_pulse;
  logic       sample_tick;
`ifdef GPIO_COND_GLITCH_STATS_EN
  logic [15:0] glitch_count;
`endif

  gpio_input_conditioner #(
    .GPIO_WIDTH   (8),
    .SYNC_STAGES  (2),
    .PRESCALE_DIV (4),
    .DB_COUNT     (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pins_raw     (pins_raw),
    .bypass       (bypass),
    .pins_clean   (pins_clean),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .sample_tick  (sample_tick)
`ifdef GPIO_COND_GLITCH_STATS_EN
    ,
    .glitch_count (glitch_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int ph = 0;  // edges since the last edge that sampled rst high

  typedef struct {
    logic [7:0] raw;
    logic [7:0] clean;
    logic [7:0] rise;
    logic [7:0] fall;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    logic r;
    r = rst;
    @(posedge clk);
    #1;
    if (r) ph = 0;
    else ph++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  initial begin
    int found, rises, falls, ticks;
    logic [7:0] prev;
    logic acc;

    vecs[0] = '{raw: 8'hA5, clean: 8'hA5, rise: 8'hA5, fall: 8'h00};
    vecs[1] = '{raw: 8'h3C, clean: 8'h3C, rise: 8'h18, fall: 8'h81};
    vecs[2] = '{raw: 8'hFF, clean: 8'hFF, rise: 8'hC3, fall: 8'h00};
    vecs[3] = '{raw: 8'h0F, clean: 8'h0F, rise: 8'h00, fall: 8'hF0};
    vecs[4] = '{raw: 8'h00, clean: 8'h00, rise: 8'h00, fall: 8'h0F};

    // 1. reset and idle
    rst = 1'b1;
    repeat (3) step();
    chk("reset_clean", pins_clean, 0);
    chk("reset_rise", rise_pulse, 0);
    chk("reset_fall", fall_pulse, 0);
    chk("reset_tick", sample_tick, 0);
    rst = 1'b0;
    for (int n = 0; n < 13; n++) begin
      step();
      chk($sformatf("idle_tick_ph%0d", ph), sample_tick, ((ph % 4) == 3) ? 1 : 0);
      chk("idle_outputs", {pins_clean, rise_pulse, fall_pulse}, 0);
    end

    // Table: all pins bypassed, level follows after 3 cycles with one-cycle pulses
    bypass = 8'hFF;
    prev = 8'h00;
    for (int v = 0; v < 5; v++) begin
      pins_raw = vecs[v].raw;
      step();
      step();
      chk($sformatf("vec%0d_clean_early", v), pins_clean, prev);
      step();
      chk($sformatf("vec%0d_clean", v), pins_clean, vecs[v].clean);
      chk($sformatf("vec%0d_rise", v), rise_pulse, vecs[v].rise);
      chk($sformatf("vec%0d_fall", v), fall_pulse, vecs[v].fall);
      step();
      chk($sformatf("vec%0d_pulse_clear", v), {rise_pulse, fall_pulse}, 0);
      prev = vecs[v].clean;
    end
    bypass = 8'h00;
    repeat (2) step();

    // 2. debounced step on pin 0
    pins_raw[0] = 1'b1;
    found = -1; rises = 0; falls = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (rise_pulse[0]) rises++;
      if (fall_pulse[0]) falls++;
      if (found < 0 && pins_clean[0]) begin
        found = n;
        chk("step_rise_coincident", rise_pulse[0], 1);
      end
    end
    chk_range("step_latency", found, 11, 14);
    chk("step_rise_count", rises, 1);
    chk("step_fall_count", falls, 0);

    // 3. 6-cycle glitch on pin 1
    pins_raw[1] = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 6; n++) begin
      step();
      acc = acc | pins_clean[1] | rise_pulse[1] | fall_pulse[1];
    end
    pins_raw[1] = 1'b0;
    for (int n = 0; n < 20; n++) begin
      step();
      acc = acc | pins_clean[1] | rise_pulse[1] | fall_pulse[1];
    end
    chk("glitch_rejected", acc, 0);
`ifdef GPIO_COND_GLITCH_STATS_EN
    chk("glitch_count", glitch_count, 1);
`endif

    // 4. bypass on pin 2
    bypass[2] = 1'b1;
    rises = 0; falls = 0;
    pins_raw[2] = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (rise_pulse[2]) rises++;
      if (fall_pulse[2]) falls++;
      if (n == 2) chk("byp_rise_early", pins_clean[2], 0);
      if (n == 3) chk("byp_rise_level", {pins_clean[2], rise_pulse[2]}, 2'b11);
    end
    pins_raw[2] = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (rise_pulse[2]) rises++;
      if (fall_pulse[2]) falls++;
      if (n == 2) chk("byp_fall_early", pins_clean[2], 1);
      if (n == 3) chk("byp_fall_level", {pins_clean[2], fall_pulse[2]}, 2'b01);
    end
    chk("byp_rise_count", rises, 1);
    chk("byp_fall_count", falls, 1);
    bypass[2] = 1'b0;

    // 5. simultaneous update of pins 3 and 4
    pins_raw[4] = 1'b1;
    repeat (20) step();
    chk("sim_pre_debounce", pins_clean[4], 1);
    pins_raw[3] = 1'b1;
    pins_raw[4] = 1'b0;
    found = -1;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (found < 0 && pins_clean[3]) begin
        found = n;
        chk("sim_pin4_low", pins_clean[4], 0);
        chk("sim_rise3_fall4", {rise_pulse[3], fall_pulse[4]}, 2'b11);
      end
    end
    chk_range("sim_latency", found, 11, 14);

    // 6. reset in the middle of a debounce on pin 5
    pins_raw[5] = 1'b1;
    ticks = 0;
    for (int n = 0; n < 20 && ticks < 2; n++) begin
      step();
      if (sample_tick) ticks++;
    end
    chk("mid_ticks_seen", ticks, 2);
    chk("mid_pin5_pending", pins_clean[5], 0);
    rst = 1'b1;
    for (int n = 0; n < 2; n++) begin
      step();
      chk("rst_no_pulse", {rise_pulse, fall_pulse}, 0);
      chk("rst_clean", pins_clean, 0);
    end
    rst = 1'b0;
`ifdef GPIO_COND_GLITCH_STATS_EN
    chk("rst_glitch_count", glitch_count, 0);
`endif
    found = -1; ticks = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (found < 0 && pins_clean[5]) begin
        found = ph;
        chk("post_rst_rise5", rise_pulse[5], 1);
      end
      if (found < 0 && sample_tick) ticks++;
    end
    chk("post_rst_latency", found, 12);
    chk("post_rst_ticks", ticks, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_input_conditioner.md
Name: gpio_input_conditioner

Overview:
Conditions raw, asynchronous GPIO pad inputs before they reach the GPIO register block's gpio_in port.
- Each pin is synchronised through a flop chain.
- Each pin is debounced with a prescaled, per-pin stability counter.
- The block emits per-pin rise and fall pulses.
- pins_clean connects directly to the controller's gpio_in. The edge pulses are available to the interrupt logic.

Parameters:
- GPIO_WIDTH, 32, number of pins conditioned.
- SYNC_STAGES, 2, synchroniser depth; legal range ≥2.
- PRESCALE_DIV, 1000, clk cycles per debounce sample tick; legal range ≥1.
- DB_COUNT, 4, consecutive differing sample ticks required to accept a new level; legal range ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pins_raw  in  GPIO_WIDTH  asynchronous pad inputs
- bypass  in  GPIO_WIDTH  per-pin debounce bypass; 1 = synchronised level passes straight through
- pins_clean  out  GPIO_WIDTH  debounced level; feeds the controller's gpio_in
- rise_pulse  out  GPIO_WIDTH  one-cycle pulse on a pins_clean 0→1 transition
- fall_pulse  out  GPIO_WIDTH  one-cycle pulse on a pins_clean 1→0 transition
- sample_tick  out  1  prescaler strobe, one cycle wide

Behaviour:
- Reset:
  - Sync chain, pins_clean, rise_pulse, fall_pulse, sample_tick, prescaler and all pin counters go to 0.
  - A pin held high through reset produces a normal rise_pulse once debounced.
- Synchroniser:
  - syncd = output of a SYNC_STAGES-deep flop chain per pin.
  - No logic between stages.
- Prescaler:
  - Counts 0..PRESCALE_DIV-1 and wraps to 0.
  - sample_tick is registered and is 1 in the cycle the count equals PRESCALE_DIV-1.
  - PRESCALE_DIV=1 gives sample_tick=1 every cycle after reset.
- Per-pin debounce (bypass=0):
  - Counter width is clog2(DB_COUNT+1).
  - If syncd==pins_clean: counter←0 in any cycle, tick or not.
  - Else if sample_tick and counter==DB_COUNT-1: pins_clean←syncd and counter←0.
  - Else if sample_tick: counter←counter+1.
  - Else: counter holds.
- Latency (bypass=0):
  - A held input change shows on pins_clean after SYNC_STAGES + (DB_COUNT-1)·PRESCALE_DIV + 1 to SYNC_STAGES + DB_COUNT·PRESCALE_DIV cycles.
  - A pulse shorter than the minimum of that window never propagates.
- Bypass (bypass=1):
  - pins_clean←syncd every cycle; counter held at 0.
  - Latency is SYNC_STAGES+1 cycles.
  - Toggling bypass mid-debounce: 1→0 restarts counting from 0; 0→1 takes syncd on the next edge.
- Edge pulses:
  - Registered in the same edge that updates pins_clean, so they are coincident with the first cycle of the new level.
  - rise = next & ~cur; fall = ~next & cur.
  - Never both set for one pin in the same cycle.
- Simultaneous events:
  - Pins are fully independent.
  - Any number of pins may update and pulse in the same cycle.
- Reset mid-operation clears all pending counts. A post-reset change needs the full DB_COUNT ticks.

Optional Feature:
- Macro: GPIO_COND_GLITCH_STATS_EN.
- Defined:
  - Adds output port glitch_count, 16 bits.
  - Increments when any non-bypassed pin's counter is nonzero and is cleared because syncd returned to pins_clean.
  - Multiple pins rejecting a glitch in the same cycle add 1 in total.
  - Saturates at 0xFFFF; reset to 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package gpio_cond_pkg:
  - clog2 function
  - default constants for SYNC_STAGES, PRESCALE_DIV and DB_COUNT
  - GLITCH_CNT_W=16
- Sub-module gpio_debounce_bit:
  - Contains one pin's sync chain, counter, level register and edge pulses.
  - Inputs: raw, bypass, sample_tick. Outputs: level, rise, fall, glitch.
  - Instantiated GPIO_WIDTH times via generate.
- The prescaler and glitch counter live in the top level.

Test Plan (GPIO_WIDTH=8, SYNC_STAGES=2, PRESCALE_DIV=4, DB_COUNT=3):
1. Reset then idle: all outputs 0; sample_tick first high 4 cycles after rst deasserts, then every 4th cycle.
2. Step: pins_raw[0] 0→1 and held → pins_clean[0]=1 no earlier than cycle 11 and no later than cycle 14 after the change; rise_pulse[0] exactly one cycle, coincident with the change; fall_pulse[0] stays 0.
3. Glitch: pins_raw[1] high for 6 cycles then low → pins_clean[1] and both pulses stay 0; glitch_count=1 with the macro defined.
4. Bypass: bypass[2]=1; pins_raw[2] toggled 0→1→0 at 10-cycle spacing → pins_clean[2] follows 3 cycles after each toggle; one rise_pulse[2], then one fall_pulse[2].
5. Simultaneous: pins_clean[4] pre-debounced to 1, then pins_raw[3] 0→1 and pins_raw[4] 1→0 in the same cycle → both update in the same cycle; rise_pulse[3] and fall_pulse[4] coincident.
6. Reset mid-debounce: pins_raw[5] high, rst pulsed after 2 ticks → after release, pins_clean[5] rises only after a full 3 further ticks; no pulse is produced during reset.
